speed_meter_ctrl: RTL and testbench
===================================

# speed_meter_ctrl

Sequencer for one `speed_meter` instance: generates the periodic time-base trigger and drives the force-reset/unlock handshake across enable and disable. It screens the meter's output samples and optionally flags a motor stall. It sits between the motor-control register block and the meter, with one instance per measured axis.

## Interface
Parameters:
- `K_WIDTH`, 32, speed/step width; matches the meter.
- `P_WIDTH`, 24, time-base period counter width.
- `S_WIDTH`, 4, settle and stall window counter width.

Ports:
- `i_clk` in 1 — system clock.
- `i_rst_n` in 1 — asynchronous, active-low reset.
- `i_enable` in 1 — measurement enable, level.
- `i_period` in P_WIDTH — time-base period in clock cycles; 0 is treated as 1.
- `i_step` in K_WIDTH — step per speed event, passed through.
- `i_settle_win` in S_WIDTH — number of discarded windows before unlock.
- `i_stall_thr` in K_WIDTH — stall threshold, unsigned.
- `i_stall_win` in S_WIDTH — consecutive low samples needed to declare a stall; 0 is treated as 1.
- `i_meter_speed` in K_WIDTH — meter `o_speed`.
- `i_meter_valid` in 1 — meter `o_valid`.
- `o_time_trigger` out 1 — to meter `i_time_trigger`.
- `o_force_reset` out 1 — to meter `i_force_reset`.
- `o_unlock` out 1 — to meter `i_unlock`.
- `o_step_size` out K_WIDTH — to meter `i_step_size`, equal to `i_step`.
- `o_speed` out K_WIDTH — last accepted speed.
- `o_speed_valid` out 1 — one-cycle pulse when `o_speed` updates.
- `o_stall` out 1 — stall flag, level.

## Operation
- FSM states are IDLE, SETTLE, RUN and STALL. Reset state is IDLE.
- Time base: a P_WIDTH counter runs in every state except IDLE.
  - `o_time_trigger` is registered and high for one cycle when count == max(`i_period`,1)−1; the count then wraps to 0.
  - `i_period` is sampled only at the wrap.
  - In IDLE the counter is held at 0 and the trigger stays low.
- IDLE:
  - `o_force_reset`=1, `o_unlock`=0.
  - On `i_enable`=1, go to SETTLE and clear the settle counter.
- SETTLE:
  - `o_force_reset`=0.
  - Each trigger increments the settle counter.
  - On the trigger where the counter equals `i_settle_win`, `o_unlock`=1 for that cycle only, coincident with `o_time_trigger`. Go to RUN with the discard flag set.
- RUN:
  - On `i_meter_valid`: if the discard flag is set, clear it and drop the sample (the meter reports 0 on the unlock window).
  - Otherwise `o_speed` ← `i_meter_speed` and `o_speed_valid` pulses.
  - Stall counting:
    - An accepted sample < `i_stall_thr` increments the low counter, which saturates at all-ones.
    - A sample ≥ `i_stall_thr` clears it.
    - When the counter reaches max(`i_stall_win`,1), go to STALL.
- STALL:
  - `o_stall`=1 and samples are still accepted.
  - The first accepted sample ≥ `i_stall_thr` returns the FSM to RUN, clears `o_stall` and clears the low counter.
- `i_enable`=0 in any state:
  - Next cycle go to IDLE.
  - Clear `o_speed`, `o_stall`, all counters and the discard flag.
  - `i_meter_valid` arriving on the disable cycle is dropped.
- `o_step_size` is combinational, equal to `i_step`.

## Timing
- Reset values:
  - `o_time_trigger`=0, `o_force_reset`=1, `o_unlock`=0.
  - `o_speed`=0, `o_speed_valid`=0, `o_stall`=0.
- Enable latency:
  - The first trigger comes max(`i_period`,1) cycles after the first cycle in SETTLE.
  - The unlock comes on trigger number `i_settle_win`+1.
- Meter `o_valid` follows the trigger by 1 cycle.
- `o_speed`/`o_speed_valid` follow `i_meter_valid` by 1 cycle, so a trigger produces accepted data 2 cycles later.
- `o_stall` rises or falls in the same cycle as the `o_speed_valid` of the deciding sample.
- Enable and disable are level-sampled each cycle. An enable pulse lasting 1 cycle enters SETTLE, then returns to IDLE on the next cycle.
- Asynchronous reset mid-operation returns all outputs to their reset values immediately. The meter relocks because `o_force_reset`=1.

## Configuration
- `SPEED_METER_CTRL_STALL_EN` defined: stall counter, STALL state and `o_stall` are implemented as described.
- Macro undefined:
  - No stall logic; `o_stall` is tied 0.
  - `i_stall_thr` and `i_stall_win` are unused.
  - The FSM never leaves RUN except through disable.

## Test plan
- Reset released with `i_enable`=0 → `o_force_reset`=1 and no `o_time_trigger` for 100 cycles.
- `i_period`=10, `i_settle_win`=2, enable at cycle 0 → triggers at cycles 10, 20 and 30; `o_unlock` only at cycle 30; first `o_speed_valid` after the cycle-40 trigger, at cycle 42.
- `i_period`=0 → a trigger every cycle once enabled.
- Meter speeds 500, 5, 5, 5 with `i_stall_thr`=10, `i_stall_win`=3 → `o_stall` rises with the third 5; a following sample of 20 clears it.
- Disable in RUN with `i_meter_valid` on the same cycle → no `o_speed_valid`; `o_speed`=0 and `o_force_reset`=1 the next cycle.
- Build without `SPEED_METER_CTRL_STALL_EN`, repeat the stall stimulus → `o_stall` stays 0 and all samples are accepted.

Source files
------------

// File: rtl/speed_meter_ctrl.sv
// ============================================================================
// speed_meter_ctrl
// ----------------------------------------------------------------------------
// Sequencer for one speed_meter instance (one per measured axis). It generates
// the periodic time-base trigger, drives the meter's force-reset/unlock
// handshake across enable/disable, screens the meter's output samples (the
// first sample after unlock is dropped) and optionally flags a motor stall.
//
// Build option:
//   SPEED_METER_CTRL_STALL_EN  defined   -> stall counter, STALL state, o_stall
//                              undefined -> no stall logic, o_stall tied 0
//
// Ports:
//   i_clk, i_rst_n    system clock, asynchronous active-low reset
//   i_enable          measurement enable (level)
//   i_period          time-base period in clocks (0 treated as 1)
//   i_step            step per speed event, passed through to o_step_size
//   i_settle_win      number of discarded windows before unlock
//   i_stall_thr       stall threshold (unsigned)
//   i_stall_win       consecutive low samples to declare stall (0 -> 1)
//   i_meter_speed     meter o_speed
//   i_meter_valid     meter o_valid
//   o_time_trigger    meter i_time_trigger (registered one-cycle pulse)
//   o_force_reset     meter i_force_reset (high while idle)
//   o_unlock          meter i_unlock (one-cycle pulse with the last settle trigger)
//   o_step_size       meter i_step_size (= i_step)
//   o_speed           last accepted speed
//   o_speed_valid     one-cycle pulse when o_speed updates
//   o_stall           stall flag (level)
// ============================================================================
module speed_meter_ctrl #(
    parameter int K_WIDTH = 32,
    parameter int P_WIDTH = 24,
    parameter int S_WIDTH = 4
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    input  logic               i_enable,
    input  logic [P_WIDTH-1:0] i_period,
    input  logic [K_WIDTH-1:0] i_step,
    input  logic [S_WIDTH-1:0] i_settle_win,
    input  logic [K_WIDTH-1:0] i_stall_thr,
    input  logic [S_WIDTH-1:0] i_stall_win,
    input  logic [K_WIDTH-1:0] i_meter_speed,
    input  logic               i_meter_valid,
    output logic               o_time_trigger,
    output logic               o_force_reset,
    output logic               o_unlock,
    output logic [K_WIDTH-1:0] o_step_size,
    output logic [K_WIDTH-1:0] o_speed,
    output logic               o_speed_valid,
    output logic               o_stall
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETTLE = 2'd1,
        ST_RUN    = 2'd2,
        ST_STALL  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [P_WIDTH-1:0] tb_cnt_q;
    logic [P_WIDTH-1:0] period_q;
    logic [P_WIDTH-1:0] period_eff;
    logic               wrap;
    logic [S_WIDTH-1:0] settle_cnt_q;
    logic               settle_done;
    logic               discard_q;
    logic               trig_q;
    logic               unlock_q;
    logic [K_WIDTH-1:0] speed_q;
    logic               speed_valid_q;
    logic               sampling;
    logic               accept;
    logic               low_sample;
    logic               stall_hit;

    // A zero period would never wrap; treat it as one cycle.
    assign period_eff  = (i_period == '0) ? P_WIDTH'(1) : i_period;
    assign wrap        = (tb_cnt_q == period_q - P_WIDTH'(1));
    assign settle_done = wrap && (settle_cnt_q == i_settle_win);

    // Samples are only looked at in RUN/STALL while enabled; the first one
    // after unlock is the meter's zero-filled unlock window and is dropped.
    assign sampling = i_enable && i_meter_valid &&
                      ((state_q == ST_RUN) || (state_q == ST_STALL));
    assign accept   = sampling && !discard_q;

`ifdef SPEED_METER_CTRL_STALL_EN
    logic [S_WIDTH-1:0] low_cnt_q;
    logic [S_WIDTH-1:0] low_inc;
    logic [S_WIDTH-1:0] stall_win_eff;

    assign low_sample    = (i_meter_speed < i_stall_thr);
    assign low_inc       = (&low_cnt_q) ? low_cnt_q : low_cnt_q + S_WIDTH'(1);
    assign stall_win_eff = (i_stall_win == '0) ? S_WIDTH'(1) : i_stall_win;
    assign stall_hit     = low_sample && (low_inc >= stall_win_eff);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            low_cnt_q <= '0;
        end else if (!i_enable || (state_q == ST_IDLE)) begin
            low_cnt_q <= '0;
        end else if (accept) begin
            low_cnt_q <= low_sample ? low_inc : '0;
        end
    end

    assign o_stall = (state_q == ST_STALL);
`else
    logic unused_stall_inputs;

    assign low_sample          = 1'b0;
    assign stall_hit           = 1'b0;
    assign unused_stall_inputs = ^{i_stall_thr, i_stall_win};
    assign o_stall             = 1'b0;
`endif

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            // NOTE: registers take <= so every flop sees pre-edge values;
            // blocking here would make the result depend on block ordering.
            state_q <= state_d;
        end
    end

    always_comb begin
        // NOTE: default first, so no path leaves state_d unassigned (latch).
        state_d = state_q;
        if (!i_enable) begin
            state_d = ST_IDLE;
        end else begin
            unique case (state_q)
                ST_IDLE:   state_d = ST_SETTLE;
                // Leave SETTLE in the unlock cycle itself, so any sample from
                // an earlier settle trigger is still ignored by SETTLE.
                ST_SETTLE: if (unlock_q) state_d = ST_RUN;
                ST_RUN:    if (accept && stall_hit) state_d = ST_STALL;
                ST_STALL:  if (accept && !low_sample) state_d = ST_RUN;
                default:   state_d = ST_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Time base, settle counter, trigger and unlock pulses
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tb_cnt_q     <= '0;
            period_q     <= P_WIDTH'(1);
            settle_cnt_q <= '0;
            trig_q       <= 1'b0;
            unlock_q     <= 1'b0;
        end else if (!i_enable || (state_q == ST_IDLE)) begin
            // Held in IDLE; the period is preloaded so the first window uses
            // the value present when SETTLE starts.
            tb_cnt_q     <= '0;
            period_q     <= period_eff;
            settle_cnt_q <= '0;
            trig_q       <= 1'b0;
            unlock_q     <= 1'b0;
        end else begin
            trig_q   <= wrap;
            unlock_q <= (state_q == ST_SETTLE) && settle_done;
            if (wrap) begin
                tb_cnt_q <= '0;
                period_q <= period_eff;
            end else begin
                tb_cnt_q <= tb_cnt_q + P_WIDTH'(1);
            end
            if ((state_q == ST_SETTLE) && wrap) begin
                settle_cnt_q <= settle_cnt_q + S_WIDTH'(1);
            end
        end
    end

    // ------------------------------------------------------------------
    // Sample screening and output register
    // ------------------------------------------------------------------
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            discard_q     <= 1'b0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
        end else if (!i_enable) begin
            discard_q     <= 1'b0;
            speed_q       <= '0;
            speed_valid_q <= 1'b0;
        end else begin
            if ((state_q == ST_SETTLE) && (state_d == ST_RUN)) begin
                discard_q <= 1'b1;
            end else if (sampling) begin
                discard_q <= 1'b0;
            end
            speed_valid_q <= accept;
            if (accept) begin
                speed_q <= i_meter_speed;
            end
        end
    end

    assign o_time_trigger = trig_q;
    assign o_unlock       = unlock_q;
    assign o_force_reset  = (state_q == ST_IDLE);
    assign o_step_size    = i_step;
    assign o_speed        = speed_q;
    assign o_speed_valid  = speed_valid_q;

endmodule

// File: tb/tb_speed_meter_ctrl.sv
// ============================================================================
// tb_speed_meter_ctrl
// ----------------------------------------------------------------------------
// Self-checking bench for speed_meter_ctrl. A small meter stand-in answers each
// trigger with a sample one cycle later. Expected trigger/unlock/force-reset
// timing is computed arithmetically from the session start; the expected
// accepted samples (value, stall flag, cycle) are pushed into a scoreboard by
// the stand-in and popped by a monitor whenever o_speed_valid pulses.
// ============================================================================
module tb_speed_meter_ctrl;

    localparam int KW = 32;
    localparam int PW = 24;
    localparam int SW = 4;

    logic          clk;
    logic          rst_n;
    logic          i_enable;
    logic [PW-1:0] i_period;
    logic [KW-1:0] i_step;
    logic [SW-1:0] i_settle_win;
    logic [KW-1:0] i_stall_thr;
    logic [SW-1:0] i_stall_win;
    logic [KW-1:0] i_meter_speed;
    logic          i_meter_valid;
    logic          o_time_trigger;
    logic          o_force_reset;
    logic          o_unlock;
    logic [KW-1:0] o_step_size;
    logic [KW-1:0] o_speed;
    logic          o_speed_valid;
    logic          o_stall;

    speed_meter_ctrl #(.K_WIDTH(KW), .P_WIDTH(PW), .S_WIDTH(SW)) dut (
        .i_clk         (clk),
        .i_rst_n       (rst_n),
        .i_enable      (i_enable),
        .i_period      (i_period),
        .i_step        (i_step),
        .i_settle_win  (i_settle_win),
        .i_stall_thr   (i_stall_thr),
        .i_stall_win   (i_stall_win),
        .i_meter_speed (i_meter_speed),
        .i_meter_valid (i_meter_valid),
        .o_time_trigger(o_time_trigger),
        .o_force_reset (o_force_reset),
        .o_unlock      (o_unlock),
        .o_step_size   (o_step_size),
        .o_speed       (o_speed),
        .o_speed_valid (o_speed_valid),
        .o_stall       (o_stall)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [KW-1:0] speed;
        bit            stall;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    logic [KW-1:0] speed_plan[$];
    int            checks = 0;
    int            errors = 0;

    // Session description (what the reference model knows).
    bit            sess_on = 0;
    int            s_cyc = 0;
    int            end_cyc = 0;
    int            per_eff = 1;
    int            sw_m = 0;
    logic [KW-1:0] thr_m = '0;
    int            win_m = 1;
    int            low_m = 0;
    bit            stall_m = 0;
    int            first_valid_cyc = -1;

    bit stub_fire = 0;
    int stub_k = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ------------------------------------------------------------------
    // Monitor: timing of trigger/unlock/force-reset and scoreboard pops
    // ------------------------------------------------------------------
    always @(negedge clk) begin : monitor
        bit   in_win;
        bit   exp_trig;
        int   k;
        exp_t e;
        in_win   = sess_on && (cyc >= s_cyc) && (cyc <= end_cyc);
        exp_trig = in_win && (cyc > s_cyc) && (((cyc - s_cyc) % per_eff) == 0);
        k        = exp_trig ? (cyc - s_cyc) / per_eff : 0;
        if (exp_trig || o_time_trigger) check("time_trigger", 64'(o_time_trigger), 64'(exp_trig));
        if (exp_trig || o_unlock) check("unlock", 64'(o_unlock), 64'(exp_trig && (k == sw_m + 1)));
        check("force_reset", 64'(o_force_reset), 64'(!in_win));
        if (o_time_trigger) begin
            stub_fire = 1;
            stub_k    = k;
        end
        if (o_speed_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_speed_valid: got speed %0d expected no output (cycle %0d)", o_speed, cyc);
            end else begin
                e = sb_q.pop_front();
                check("speed", 64'(o_speed), 64'(e.speed));
                check("stall", 64'(o_stall), 64'(e.stall));
                check("speed_latency", 64'(cyc), 64'(e.cyc));
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
        end
    end

    // ------------------------------------------------------------------
    // Meter stand-in + reference model: a sample one cycle after each
    // trigger. It is accepted when the session is still enabled and the
    // trigger came after the unlock trigger (number settle_win+1).
    // ------------------------------------------------------------------
    always @(posedge clk) begin : meter_stub
        logic [KW-1:0] spd;
        bit            acc;
        #2;
        if (stub_fire) begin
            stub_fire = 0;
            acc = i_enable && sess_on && (stub_k >= sw_m + 2);
            if (acc && speed_plan.size() > 0) spd = speed_plan.pop_front();
            else                              spd = KW'($urandom_range(1, 40));
            if (acc) begin
`ifdef SPEED_METER_CTRL_STALL_EN
                if (spd < thr_m) begin
                    if (low_m < 15) low_m++;
                    if (low_m >= win_m) stall_m = 1;
                end else begin
                    low_m   = 0;
                    stall_m = 0;
                end
`else
                stall_m = 0;
`endif
                sb_q.push_back('{speed: spd, stall: stall_m, cyc: cyc + 1});
            end
            i_meter_valid = 1'b1;
            i_meter_speed = spd;
        end else begin
            i_meter_valid = 1'b0;
            i_meter_speed = $urandom;
        end
    end

    // ------------------------------------------------------------------
    // Driver helpers
    // ------------------------------------------------------------------
    task automatic start_session(input int per, input int sw, input int thr, input int win);
        @(posedge clk); #1;
        i_period     = PW'(per);
        i_settle_win = SW'(sw);
        i_stall_thr  = KW'(thr);
        i_stall_win  = SW'(win);
        per_eff      = (per == 0) ? 1 : per;
        sw_m         = sw;
        thr_m        = KW'(thr);
        win_m        = (win == 0) ? 1 : win;
        low_m        = 0;
        stall_m      = 0;
        @(posedge clk); #1;
        i_enable        = 1'b1;
        s_cyc           = cyc + 1;
        end_cyc         = 1 << 30;
        first_valid_cyc = -1;
        sess_on         = 1;
    endtask

    task automatic end_session();
        @(posedge clk); #1;
        i_enable = 1'b0;
        end_cyc  = cyc;
        repeat (4) @(posedge clk);
        #1;
        check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation exceeded time limit (cycle %0d)", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        bit done;
        rst_n         = 1'b0;
        i_enable      = 1'b0;
        i_period      = '0;
        i_step        = '0;
        i_settle_win  = '0;
        i_stall_thr   = '0;
        i_stall_win   = '0;
        i_meter_speed = '0;
        i_meter_valid = 1'b0;

        // Reset values
        #3;
        check("rst_trigger", 64'(o_time_trigger), 64'd0);
        check("rst_force_reset", 64'(o_force_reset), 64'd1);
        check("rst_unlock", 64'(o_unlock), 64'd0);
        check("rst_speed", 64'(o_speed), 64'd0);
        check("rst_speed_valid", 64'(o_speed_valid), 64'd0);
        check("rst_stall", 64'(o_stall), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Idle with enable low: no triggers for 100 cycles
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (o_time_trigger) n++;
        end
        check("idle_no_trigger", 64'(n), 64'd0);

        // Step size pass-through
        repeat (3) begin
            logic [KW-1:0] st;
            st = $urandom;
            i_step = st;
            #1 check("step_size", 64'(o_step_size), 64'(st));
        end

        // Period 10, settle 2: unlock on trigger 3, first data 42 cycles in
        start_session(10, 2, 0, 1);
        repeat (60) @(posedge clk);
        check("first_valid_offset", 64'(first_valid_cyc - s_cyc), 64'd42);
        end_session();

        // Period 0 behaves as 1: trigger every cycle
        start_session(0, 1, 0, 1);
        repeat (30) @(posedge clk);
        end_session();

        // Stall scenario, then disable on a cycle carrying a meter sample
        start_session(4, 0, 10, 3);
        speed_plan = '{32'd500, 32'd5, 32'd5, 32'd5, 32'd20, 32'd5, 32'd5, 32'd5};
        done = 0;
        for (int i = 0; i < 200 && !done; i++) begin
            @(posedge clk);
            done = (speed_plan.size() == 0) && (sb_q.size() == 0);
        end
        check("stall_plan_consumed", 64'(done), 64'd1);
`ifdef SPEED_METER_CTRL_STALL_EN
        #1 check("stall_level_held", 64'(o_stall), 64'd1);
`else
        #1 check("stall_level_held", 64'(o_stall), 64'd0);
`endif
        done = 0;
        for (int i = 0; i < 50 && !done; i++) begin
            @(negedge clk);
            done = o_time_trigger && (((cyc - s_cyc) / per_eff) >= sw_m + 2);
        end
        check("disable_trigger_seen", 64'(done), 64'd1);
        @(posedge clk); #1;
        i_enable = 1'b0;
        end_cyc  = cyc;
        @(posedge clk); #1;
        check("disable_speed_cleared", 64'(o_speed), 64'd0);
        check("disable_force_reset", 64'(o_force_reset), 64'd1);
        check("disable_stall_cleared", 64'(o_stall), 64'd0);
        repeat (3) @(posedge clk);
        #1 check("scoreboard_drained", 64'(sb_q.size()), 64'd0);

        // One-cycle enable pulse
        start_session(1, 0, 0, 1);
        end_session();

        // Asynchronous reset in the middle of RUN
        start_session(3, 1, 15, 2);
        repeat (30) @(posedge clk);
        #3;
        sess_on   = 0;
        i_enable  = 1'b0;
        rst_n     = 1'b0;
        stub_fire = 0;
        #1;
        sb_q.delete();
        check("arst_trigger", 64'(o_time_trigger), 64'd0);
        check("arst_force_reset", 64'(o_force_reset), 64'd1);
        check("arst_unlock", 64'(o_unlock), 64'd0);
        check("arst_speed", 64'(o_speed), 64'd0);
        check("arst_speed_valid", 64'(o_speed_valid), 64'd0);
        check("arst_stall", 64'(o_stall), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // Randomized sessions
        for (int s = 0; s < 10; s++) begin
            start_session($urandom_range(0, 6), $urandom_range(0, 3),
                          $urandom_range(0, 30), $urandom_range(0, 4));
            repeat ($urandom_range(0, 90)) @(posedge clk);
            end_session();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
